// File: rtl/vga_scan_timer_if.sv
// ----------------------------------------------------------------------------
// vga_scan_timer_if
//
// Purpose: bundles the raster-timing outputs of vga_scan_timer so that one
// connection carries the whole scan state to the sprite stages.
//
// Signals:
//   pix_tick     pixel-rate enable, one clk wide
//   hcount       horizontal position, 0..H_TOTAL-1
//   vcount       vertical position, 0..V_TOTAL-1
//   hsync        horizontal sync, active-low
//   vsync        vertical sync, active-low
//   video_on     high inside the visible region
//   update       once-per-frame strobe (first pixel of vertical blanking)
//   frame_count  frames completed, wraps 255->0
//
// Valid/ready: there is no handshake. Every signal is valid on every clk;
// consumers sample hcount/vcount each clk and treat a rising update as the
// frame event.
//
// Modports:
//   master  driven by the timing generator
//   slave   read by downstream sprite/game-state stages
// ----------------------------------------------------------------------------
interface vga_scan_timer_if;
    logic       pix_tick;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       update;
    logic [7:0] frame_count;

    modport master (
        output pix_tick,
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output video_on,
        output update,
        output frame_count
    );

    modport slave (
        input pix_tick,
        input hcount,
        input vcount,
        input hsync,
        input vsync,
        input video_on,
        input update,
        input frame_count
    );
endinterface

// File: rtl/vga_scan_timer.sv
// ----------------------------------------------------------------------------
// vga_scan_timer
//
// Purpose: raster timing generator for the 640x480 @ 60 Hz display path.
// Divides clk down to the pixel rate, runs the horizontal/vertical position
// counters, and produces registered sync, active-video and frame-strobe
// outputs that are coherent with the counters in the same cycle.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   vga   out  vga_scan_timer_if.master: pix_tick, hcount, vcount, hsync,
//              vsync, video_on, update, frame_count
//
// Parameters: CLK_DIV (system clocks per pixel, >=1), horizontal
// H_ACTIVE/H_FP/H_SYNC/H_BP in pixels, vertical V_ACTIVE/V_FP/V_SYNC/V_BP in
// lines. All parameter sums are expected to stay below 1024.
// ----------------------------------------------------------------------------
module vga_scan_timer #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk,
    input  logic             rst,
    vga_scan_timer_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // ------------------------------------------------------------------------
    // Pixel-rate divider. pix_tick is decoded from the divider register, so
    // it is high during the last system clock of each pixel period and the
    // counters move on the edge that ends that clock.
    // ------------------------------------------------------------------------
    logic w_pix_tick;

    if (CLK_DIV > 1) begin : g_div
        localparam int              DIV_W    = $clog2(CLK_DIV);
        localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

        logic [DIV_W-1:0] r_div_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_div_cnt <= '0;
            end else if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end

        assign w_pix_tick = (r_div_cnt == DIV_LAST);
    end else begin : g_nodiv
        // One system clock per pixel: every clock is a pixel clock.
        assign w_pix_tick = 1'b1;
    end

    // ------------------------------------------------------------------------
    // Position counters and registered decodes
    // ------------------------------------------------------------------------
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_update;
    logic [7:0] r_frame_count;

    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_hsync_next;
    logic       w_vsync_next;
    logic       w_video_on_next;
    logic       w_update_next;

    // Next-state counters: hold unless this is a pixel tick.
    always_comb begin
        w_h_next = r_hcount;
        w_v_next = r_vcount;
        if (w_pix_tick) begin
            if (r_hcount == H_LAST) begin
                w_h_next = '0;
                if (r_vcount == V_LAST) begin
                    w_v_next = '0;
                end else begin
                    w_v_next = r_vcount + 10'd1;
                end
            end else begin
                w_h_next = r_hcount + 10'd1;
            end
        end
    end

    // Decodes are taken from the next-state counters so the registered
    // outputs line up with hcount/vcount on the very same edge.
    always_comb begin
        w_hsync_next    = !((w_h_next >= HS_START) && (w_h_next <= HS_END));
        w_vsync_next    = !((w_v_next >= VS_START) && (w_v_next <= VS_END));
        w_video_on_next = (w_h_next < H_ACT) && (w_v_next < V_ACT);
        w_update_next   = (w_v_next == V_ACT) && (w_h_next == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_update      <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_hcount   <= w_h_next;
            r_vcount   <= w_v_next;
            r_hsync    <= w_hsync_next;
            r_vsync    <= w_vsync_next;
            r_video_on <= w_video_on_next;
            r_update   <= w_update_next;
            // Count a frame on the edge the counters step onto the first
            // blanking line; a tick always moves the counters, so this fires
            // once per frame, together with the rising update.
            if (w_pix_tick && w_update_next) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign vga.pix_tick    = w_pix_tick;
    assign vga.hcount      = r_hcount;
    assign vga.vcount      = r_vcount;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.video_on    = r_video_on;
    assign vga.update      = r_update;
    assign vga.frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_scan_timer.sv
// ----------------------------------------------------------------------------
// tb_vga_scan_timer
//
// Three timer instances share one clock and reset:
//   u_full   default 640x480 timing, CLK_DIV=2 (line-level timing)
//   u_small  shrunken raster 12x8, CLK_DIV=2 (frame-level timing, rollover)
//   u_div1   shrunken raster 12x8, CLK_DIV=1
// The reference model derives every output from the number of clock edges
// since reset was released, using plain division and modulo.
// ----------------------------------------------------------------------------
module tb_vga_scan_timer;

    localparam int S_HA = 6;
    localparam int S_HF = 2;
    localparam int S_HS = 2;
    localparam int S_HB = 2;
    localparam int S_VA = 4;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 1;

    typedef struct packed {
        int d;
        int ha;
        int hf;
        int hs;
        int hb;
        int va;
        int vf;
        int vs;
        int vb;
    } cfg_t;

    typedef struct packed {
        logic       tick;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       upd;
        logic [7:0] fc;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_scan_timer_if if_full ();
    vga_scan_timer_if if_small ();
    vga_scan_timer_if if_div1 ();

    vga_scan_timer #(.CLK_DIV(2)) u_full (
        .clk (clk),
        .rst (rst),
        .vga (if_full)
    );

    vga_scan_timer #(
        .CLK_DIV(2), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .vga (if_small)
    );

    vga_scan_timer #(
        .CLK_DIV(1), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_div1 (
        .clk (clk),
        .rst (rst),
        .vga (if_div1)
    );

    // Edges since reset release, and whether the last edge saw reset.
    int t      = 0;
    bit in_rst = 1'b1;
    always @(posedge clk) begin
        if (rst) begin
            t      <= 0;
            in_rst <= 1'b1;
        end else begin
            t      <= t + 1;
            in_rst <= 1'b0;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    function automatic exp_t model(input cfg_t c, input int tt, input bit rs);
        exp_t e;
        int ht, vt, frame, px, pos, h, v, first_upd;
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        frame = ht * vt;
        if (rs) begin
            e.tick = (c.d == 1);
            e.h    = '0;
            e.v    = '0;
            e.hs   = 1'b1;
            e.vs   = 1'b1;
            e.von  = 1'b0;
            e.upd  = 1'b0;
            e.fc   = '0;
            return e;
        end
        e.tick    = (c.d == 1) || ((tt % c.d) == c.d - 1);
        px        = tt / c.d;
        pos       = px % frame;
        h         = pos % ht;
        v         = pos / ht;
        e.h       = 10'(h);
        e.v       = 10'(v);
        e.hs      = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs));
        e.vs      = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs));
        e.von     = (h < c.ha) && (v < c.va);
        e.upd     = (h == 0) && (v == c.va);
        first_upd = c.va * ht;
        e.fc      = (px >= first_upd) ? 8'((((px - first_upd) / frame) + 1) % 256) : 8'd0;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(5);
        n_vec++;
        if ({if_full.hcount, if_full.vcount} !== 20'd0) begin
            n_err++;
            $display("FAIL rst_counters: got h=%0d v=%0d, want 0 0", if_full.hcount, if_full.vcount);
        end
        n_vec++;
        if ({if_full.hsync, if_full.vsync, if_full.video_on, if_full.update, if_full.pix_tick} !== 5'b11000) begin
            n_err++;
            $display("FAIL rst_flags: got hs/vs/von/upd/tick=%b, want 11000",
                     {if_full.hsync, if_full.vsync, if_full.video_on, if_full.update, if_full.pix_tick});
        end
        n_vec++;
        if (if_full.frame_count !== 8'd0) begin
            n_err++;
            $display("FAIL rst_frame_count: got %0d, want 0", if_full.frame_count);
        end
        n_vec++;
        if (if_div1.pix_tick !== 1'b1) begin
            n_err++;
            $display("FAIL rst_div1_tick: got %b, want 1", if_div1.pix_tick);
        end
        step();
        n_vec++;
        if ({if_full.video_on, if_full.pix_tick, if_full.hcount, if_full.vcount} !== {2'b11, 20'd0}) begin
            n_err++;
            $display("FAIL first_edge: got von=%b tick=%b h=%0d v=%0d, want 1 1 0 0",
                     if_full.video_on, if_full.pix_tick, if_full.hcount, if_full.vcount);
        end
        step();
        n_vec++;
        if ({if_full.pix_tick, if_full.hcount} !== {1'b0, 10'd1}) begin
            n_err++;
            $display("FAIL second_edge: got tick=%b h=%0d, want 0 1", if_full.pix_tick, if_full.hcount);
        end
    endtask

    task automatic test_horizontal();
        int lines, period, hs_low, vid, fall_h, rise_h;
        bit started;
        logic prev_hs;
        logic [9:0] prev_h;
        do_reset(2);
        lines = 0; started = 0; period = 0; hs_low = 0; vid = 0; fall_h = -1; rise_h = -1;
        prev_hs = if_full.hsync;
        prev_h  = if_full.hcount;
        for (int i = 0; i < 4900 && lines < 2; i++) begin
            step();
            if (prev_h == 10'd799 && if_full.hcount == 10'd0) begin
                if (started) begin
                    n_vec++;
                    if (period != 1600) begin n_err++; $display("FAIL line_period: got %0d clks, want 1600", period); end
                    n_vec++;
                    if (hs_low != 192) begin n_err++; $display("FAIL hsync_width: got %0d clks, want 192", hs_low); end
                    n_vec++;
                    if (vid != 1280) begin n_err++; $display("FAIL video_on_width: got %0d clks, want 1280", vid); end
                    n_vec++;
                    if (fall_h != 656) begin n_err++; $display("FAIL hsync_start: got hcount %0d, want 656", fall_h); end
                    n_vec++;
                    if (rise_h != 752) begin n_err++; $display("FAIL hsync_end: got hcount %0d, want 752", rise_h); end
                    lines++;
                end
                started = 1; period = 0; hs_low = 0; vid = 0; fall_h = -1; rise_h = -1;
            end
            if (started) begin
                period++;
                if (!if_full.hsync) hs_low++;
                if (if_full.video_on) vid++;
                if (prev_hs && !if_full.hsync) fall_h = int'(if_full.hcount);
                if (!prev_hs && if_full.hsync) rise_h = int'(if_full.hcount);
            end
            prev_hs = if_full.hsync;
            prev_h  = if_full.hcount;
        end
        n_vec++;
        if (lines != 2) begin n_err++; $display("FAIL lines_seen: got %0d, want 2", lines); end
    endtask

    task automatic test_vertical();
        int vs_run, vs_runs, upd_run, n_upd, last_i;
        logic prev_vs, prev_upd;
        do_reset(2);
        vs_run = 0; vs_runs = 0; upd_run = 0; n_upd = 0; last_i = 0;
        prev_vs  = if_small.vsync;
        prev_upd = if_small.update;
        for (int i = 0; i < 600; i++) begin
            step();
            if (!if_small.vsync) vs_run++;
            if (prev_vs && !if_small.vsync) begin
                n_vec++;
                if (if_small.vcount !== 10'(S_VA + S_VF)) begin
                    n_err++; $display("FAIL vsync_start: got vcount %0d, want %0d", if_small.vcount, S_VA + S_VF);
                end
            end
            if (!prev_vs && if_small.vsync) begin
                n_vec++;
                if (vs_run != S_VS * 12 * 2) begin
                    n_err++; $display("FAIL vsync_width: got %0d clks, want %0d", vs_run, S_VS * 24);
                end
                n_vec++;
                if (if_small.vcount !== 10'(S_VA + S_VF + S_VS)) begin
                    n_err++; $display("FAIL vsync_end: got vcount %0d, want %0d", if_small.vcount, S_VA + S_VF + S_VS);
                end
                vs_runs++;
                vs_run = 0;
            end
            if (if_small.update) begin
                upd_run++;
                n_vec++;
                if ({if_small.hcount, if_small.vcount} !== {10'd0, 10'(S_VA)}) begin
                    n_err++; $display("FAIL update_pos: got h=%0d v=%0d, want 0 %0d", if_small.hcount, if_small.vcount, S_VA);
                end
            end
            if (!prev_upd && if_small.update) begin
                n_upd++;
                n_vec++;
                if (if_small.frame_count !== 8'(n_upd)) begin
                    n_err++; $display("FAIL frame_step: got %0d, want %0d", if_small.frame_count, n_upd);
                end
                if (n_upd > 1) begin
                    n_vec++;
                    if (i - last_i != 192) begin
                        n_err++; $display("FAIL update_period: got %0d clks, want 192", i - last_i);
                    end
                end
                last_i = i;
            end
            if (prev_upd && !if_small.update) begin
                n_vec++;
                if (upd_run != 2) begin n_err++; $display("FAIL update_width: got %0d clks, want 2", upd_run); end
                upd_run = 0;
            end
            prev_vs  = if_small.vsync;
            prev_upd = if_small.update;
        end
        n_vec++;
        if (n_upd != 3 || vs_runs != 3) begin
            n_err++; $display("FAIL frames_seen: got updates=%0d vsyncs=%0d, want 3 3", n_upd, vs_runs);
        end
    endtask

    task automatic test_wrap();
        bit found;
        do_reset(2);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (if_small.hcount == 10'd11 && if_small.vcount == 10'd7) found = 1;
        end
        n_vec++;
        if (!found || if_small.video_on !== 1'b0) begin
            n_err++; $display("FAIL wrap_before: got found=%0d von=%b, want 1 0", found, if_small.video_on);
        end
        for (int i = 0; i < 4 && if_small.hcount == 10'd11; i++) step();
        n_vec++;
        if ({if_small.hcount, if_small.vcount, if_small.video_on, if_small.update} !== {20'd0, 2'b10}) begin
            n_err++; $display("FAIL wrap_after: got h=%0d v=%0d von=%b upd=%b, want 0 0 1 0",
                              if_small.hcount, if_small.vcount, if_small.video_on, if_small.update);
        end
        n_vec++;
        if (if_small.frame_count !== 8'd1) begin
            n_err++; $display("FAIL wrap_frame_count: got %0d, want 1", if_small.frame_count);
        end
    endtask

    task automatic test_rollover();
        int n_s, n_d;
        logic prev_s, prev_d;
        do_reset(2);
        n_s = 0; n_d = 0;
        prev_s = if_small.update;
        prev_d = if_div1.update;
        for (int i = 0; i < 50000 && n_s < 256; i++) begin
            step();
            if (!prev_s && if_small.update) begin
                n_s++;
                if (n_s >= 255) begin
                    n_vec++;
                    if (if_small.frame_count !== 8'(n_s)) begin
                        n_err++; $display("FAIL rollover_small: update %0d got %0d, want %0d", n_s, if_small.frame_count, n_s % 256);
                    end
                end
            end
            if (!prev_d && if_div1.update) begin
                n_d++;
                if (n_d == 255 || n_d == 256) begin
                    n_vec++;
                    if (if_div1.frame_count !== 8'(n_d)) begin
                        n_err++; $display("FAIL rollover_div1: update %0d got %0d, want %0d", n_d, if_div1.frame_count, n_d % 256);
                    end
                end
            end
            prev_s = if_small.update;
            prev_d = if_div1.update;
        end
        n_vec++;
        if (n_s != 256 || n_d < 256) begin
            n_err++; $display("FAIL rollover_count: got small=%0d div1=%0d, want 256 >=256", n_s, n_d);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        do_reset(2);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (if_small.hcount == 10'd3 && if_small.vcount == 10'd2) found = 1;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (!found || {if_small.hcount, if_small.vcount, if_small.hsync, if_small.vsync, if_small.video_on,
                       if_small.update, if_small.pix_tick, if_small.frame_count} !== {20'd0, 5'b11000, 8'd0}) begin
            n_err++; $display("FAIL mid_reset: got found=%0d h=%0d v=%0d von=%b tick=%b fc=%0d, want 1 0 0 0 0 0",
                              found, if_small.hcount, if_small.vcount, if_small.video_on, if_small.pix_tick, if_small.frame_count);
        end
        n_vec++;
        if (if_div1.pix_tick !== 1'b1) begin
            n_err++; $display("FAIL mid_reset_div1_tick: got %b, want 1", if_div1.pix_tick);
        end
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (if_small.update) found = 1;
        end
        n_vec++;
        if (!found || if_small.frame_count !== 8'd1) begin
            n_err++; $display("FAIL pre_update_reset: got found=%0d fc=%0d, want 1 1", found, if_small.frame_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if ({if_small.update, if_small.frame_count} !== 9'd0) begin
            n_err++; $display("FAIL update_reset: got upd=%b fc=%0d, want 0 0", if_small.update, if_small.frame_count);
        end
        repeat ($urandom_range(10, 900)) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if ({if_full.hcount, if_full.vcount, if_full.hsync, if_full.vsync, if_full.video_on, if_full.update,
             if_full.pix_tick} !== {20'd0, 5'b11000}) begin
            n_err++; $display("FAIL full_random_reset: got h=%0d v=%0d flags=%b, want 0 0 11000", if_full.hcount, if_full.vcount,
                              {if_full.hsync, if_full.vsync, if_full.video_on, if_full.update, if_full.pix_tick});
        end
    endtask

    task automatic test_clkdiv1();
        int tick_low, lines, period, hs_low, upd_run, n_upd;
        bit started;
        logic [9:0] prev_h;
        logic prev_upd;
        do_reset(2);
        tick_low = 0; lines = 0; period = 0; hs_low = 0; upd_run = 0; n_upd = 0; started = 0;
        prev_h   = if_div1.hcount;
        prev_upd = if_div1.update;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!if_div1.pix_tick) tick_low++;
            if (prev_h == 10'd11 && if_div1.hcount == 10'd0) begin
                if (started) begin
                    n_vec++;
                    if (period != 12) begin n_err++; $display("FAIL div1_line: got %0d clks, want 12", period); end
                    n_vec++;
                    if (hs_low != S_HS) begin n_err++; $display("FAIL div1_hsync: got %0d clks, want %0d", hs_low, S_HS); end
                    lines++;
                end
                started = 1; period = 0; hs_low = 0;
            end
            period++;
            if (!if_div1.hsync) hs_low++;
            if (if_div1.update) upd_run++;
            if (!prev_upd && if_div1.update) n_upd++;
            if (prev_upd && !if_div1.update) begin
                n_vec++;
                if (upd_run != 1) begin n_err++; $display("FAIL div1_update_width: got %0d clks, want 1", upd_run); end
                upd_run = 0;
            end
            prev_h   = if_div1.hcount;
            prev_upd = if_div1.update;
        end
        n_vec++;
        if (tick_low != 0) begin n_err++; $display("FAIL div1_tick_const: got %0d low clks, want 0", tick_low); end
        n_vec++;
        if (lines < 20 || n_upd != 3) begin
            n_err++; $display("FAIL div1_activity: got lines=%0d updates=%0d, want >=20 3", lines, n_upd);
        end
    endtask

    task automatic test_random();
        cfg_t cfgs[3];
        string nm[3];
        exp_t e, act;
        int len;
        cfgs[0] = '{d: 2, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33};
        cfgs[1] = '{d: 2, ha: S_HA, hf: S_HF, hs: S_HS, hb: S_HB, va: S_VA, vf: S_VF, vs: S_VS, vb: S_VB};
        cfgs[2] = '{d: 1, ha: S_HA, hf: S_HF, hs: S_HS, hb: S_HB, va: S_VA, vf: S_VF, vs: S_VS, vb: S_VB};
        nm[0] = "full"; nm[1] = "small"; nm[2] = "div1";
        for (int it = 0; it < 8; it++) begin
            do_reset($urandom_range(1, 4));
            len = $urandom_range(50, 1200);
            for (int i = 0; i < len; i++) begin
                rst = ($urandom_range(0, 299) == 0);
                step();
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    case (k)
                        0: act = {if_full.pix_tick, if_full.hcount, if_full.vcount, if_full.hsync, if_full.vsync,
                                  if_full.video_on, if_full.update, if_full.frame_count};
                        1: act = {if_small.pix_tick, if_small.hcount, if_small.vcount, if_small.hsync, if_small.vsync,
                                  if_small.video_on, if_small.update, if_small.frame_count};
                        default: act = {if_div1.pix_tick, if_div1.hcount, if_div1.vcount, if_div1.hsync, if_div1.vsync,
                                        if_div1.video_on, if_div1.update, if_div1.frame_count};
                    endcase
                    e = model(cfgs[k], t, in_rst);
                    n_vec++;
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL rand_%s t=%0d: got tick=%b h=%0d v=%0d hs=%b vs=%b von=%b upd=%b fc=%0d, want tick=%b h=%0d v=%0d hs=%b vs=%b von=%b upd=%b fc=%0d",
                                 nm[k], t, act.tick, act.h, act.v, act.hs, act.vs, act.von, act.upd, act.fc,
                                 e.tick, e.h, e.v, e.hs, e.vs, e.von, e.upd, e.fc);
                    end
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_horizontal();
        test_vertical();
        test_wrap();
        test_rollover();
        test_mid_reset();
        test_clkdiv1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
